// File: rtl/fxp_dot_accumulator_pkg.sv
// fxp_dot_accumulator_pkg
//   Shared types and constant helpers for the fixed-point dot-product
//   accumulator: FSM state encoding, accumulator width, and the
//   max/min representable values of a signed Q(wi).(wf) format.
package fxp_dot_accumulator_pkg;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_OUT   = 2'd2
  } state_e;

  // Accumulator is Q(WOI+WG).(WOF)
  function automatic int acc_width(input int woi, input int wg, input int wof);
    return woi + wg + wof;
  endfunction

  // Limits are returned as 64-bit signed integers in LSB units of the format
  function automatic logic signed [63:0] sat_max(input int wi, input int wf);
    return (64'sd1 <<< (wi + wf - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int wi, input int wf);
    return -(64'sd1 <<< (wi + wf - 1));
  endfunction

endpackage

// File: rtl/fxp_dot_accumulator_mul.sv
// fxp_dot_accumulator_mul
//   Combinational signed fixed-point multiplier. Produces A*B in
//   Q(WI).(WOF), rounding (ROUND=1) or truncating the dropped fraction,
//   and saturating with o_ovf when the product does not fit.
//   Ports:
//     i_a   [WIIA+WIFA-1:0]  operand A, two's complement Q(WIIA).(WIFA)
//     i_b   [WIIB+WIFB-1:0]  operand B, two's complement Q(WIIB).(WIFB)
//     o_p   [WI+WOF-1:0]     product, Q(WI).(WOF)
//     o_ovf                  product saturated
module fxp_dot_accumulator_mul
  import fxp_dot_accumulator_pkg::*;
#(
  parameter int WIIA  = 8,
  parameter int WIFA  = 8,
  parameter int WIIB  = 8,
  parameter int WIFB  = 8,
  parameter int WI    = 16,
  parameter int WOF   = 8,
  parameter int ROUND = 1
) (
  input  logic [WIIA+WIFA-1:0] i_a,
  input  logic [WIIB+WIFB-1:0] i_b,
  output logic [WI+WOF-1:0]    o_p,
  output logic                 o_ovf
);

  localparam int WP   = WIIA + WIFA + WIIB + WIFB;
  localparam int FP   = WIFA + WIFB;
  localparam int SH   = (FP > WOF) ? FP - WOF : 0;
  localparam int LSH  = (WOF > FP) ? WOF - FP : 0;
  localparam int RSH  = (SH > 0) ? SH - 1 : 0;
  localparam int WX   = WP + LSH + 2;  // headroom for the rounding add
  localparam int WR   = WI + WOF;
  localparam logic [WX-1:0] RND = (ROUND != 0 && SH > 0) ?
                                  ({{(WX-1){1'b0}}, 1'b1} << RSH) : {WX{1'b0}};
  localparam logic signed [63:0] PMAX = sat_max(WI, WOF);
  localparam logic signed [63:0] PMIN = sat_min(WI, WOF);

  logic signed [WP-1:0] prod;
  logic signed [WX-1:0] ext;
  logic signed [WX-1:0] scaled;
  logic signed [63:0]   s64;

  always_comb begin
    prod   = $signed(i_a) * $signed(i_b);
    ext    = WX'(prod) <<< LSH;
    // Add half an output LSB before the arithmetic shift: round half up
    scaled = (ext + $signed(RND)) >>> SH;
    s64    = 64'(scaled);
    o_ovf  = 1'b0;
    if (s64 > PMAX) begin
      o_p   = PMAX[WR-1:0];
      o_ovf = 1'b1;
    end else if (s64 < PMIN) begin
      o_p   = PMIN[WR-1:0];
      o_ovf = 1'b1;
    end else begin
      o_p   = s64[WR-1:0];
    end
  end

endmodule

// File: rtl/fxp_dot_accumulator.sv
// fxp_dot_accumulator
//   Streaming multiply-accumulate: sums A*B over a packet (delimited by
//   i_last) in a guarded Q(WOI+WG).(WOF) accumulator and emits one
//   saturated Q(WOI).(WOF) result per packet with a sticky overflow flag
//   and a saturating beat count.
//   Optional macro FXP_ACC_SATURATE_EN: accumulator clamps on overflow
//   instead of wrapping.
//   Ports:
//     clk, rstn           clock, async active-low reset
//     i_valid/i_ready     input pair handshake; i_a, i_b operands, i_last
//     o_valid/o_ready     result handshake
//     o_data              saturated dot product
//     o_overflow          any product/accumulate/final saturation overflow
//     o_count             beats in packet (saturating)
module fxp_dot_accumulator
  import fxp_dot_accumulator_pkg::*;
#(
  parameter int WIIA  = 8,
  parameter int WIFA  = 8,
  parameter int WIIB  = 8,
  parameter int WIFB  = 8,
  parameter int WOI   = 12,
  parameter int WOF   = 8,
  parameter int WG    = 4,
  parameter int ROUND = 1,
  parameter int WCNT  = 16
) (
  input  logic                 rstn,
  input  logic                 clk,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [WIIA+WIFA-1:0] i_a,
  input  logic [WIIB+WIFB-1:0] i_b,
  input  logic                 i_last,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [WOI+WOF-1:0]   o_data,
  output logic                 o_overflow,
  output logic [WCNT-1:0]      o_count
);

  localparam int WACC = acc_width(WOI, WG, WOF);
  localparam int WO   = WOI + WOF;
  localparam logic signed [63:0] OMAX = sat_max(WOI, WOF);
  localparam logic signed [63:0] OMIN = sat_min(WOI, WOF);
`ifdef FXP_ACC_SATURATE_EN
  localparam logic signed [63:0] AMAX = sat_max(WOI + WG, WOF);
  localparam logic signed [63:0] AMIN = sat_min(WOI + WG, WOF);
`endif

  state_e state_q, state_d;

  logic                   s1_vld_q,  s1_vld_d;
  logic signed [WACC-1:0] s1_prod_q, s1_prod_d;
  logic                   s1_last_q, s1_last_d;
  logic                   s1_ovf_q,  s1_ovf_d;
  logic signed [WACC-1:0] acc_q,     acc_d;
  logic                   ovf_q,     ovf_d;
  logic [WCNT-1:0]        cnt_q,     cnt_d;
  logic [WO-1:0]          od_q,      od_d;
  logic                   oovf_q,    oovf_d;
  logic [WCNT-1:0]        ocnt_q,    ocnt_d;

  logic [WACC-1:0]        mul_p;
  logic                   mul_ovf;
  logic                   hs;
  logic                   last_pending;
  logic signed [WACC-1:0] sum;
  logic signed [WACC-1:0] acc_next;
  logic                   add_ovf;
  logic signed [63:0]     a64;
  logic                   fin_hi, fin_lo;

  fxp_dot_accumulator_mul #(
    .WIIA(WIIA), .WIFA(WIFA), .WIIB(WIIB), .WIFB(WIFB),
    .WI(WOI + WG), .WOF(WOF), .ROUND(ROUND)
  ) u_mul (
    .i_a  (i_a),
    .i_b  (i_b),
    .o_p  (mul_p),
    .o_ovf(mul_ovf)
  );

  assign hs = i_valid & i_ready;
  // The last product is still in stage 1 and has not reached the accumulator
  assign last_pending = s1_vld_q & s1_last_q;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_ACC;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACC:   if (hs && i_last)  state_d = ST_FLUSH;
      // Wait one cycle for the final product to land in the accumulator,
      // then capture the saturated result.
      ST_FLUSH: if (!last_pending) state_d = ST_OUT;
      ST_OUT:   if (o_ready)       state_d = ST_ACC;
      default:                     state_d = ST_ACC;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    // rstn gating keeps i_ready low throughout reset
    i_ready = rstn && (state_q == ST_ACC);
    o_valid = (state_q == ST_OUT);
  end

  // ---------------- Datapath ----------------
  always_comb begin
    sum     = acc_q + s1_prod_q;
    // Same-sign operands producing a different-sign result
    add_ovf = (acc_q[WACC-1] == s1_prod_q[WACC-1]) && (sum[WACC-1] != acc_q[WACC-1]);
`ifdef FXP_ACC_SATURATE_EN
    if (add_ovf) acc_next = acc_q[WACC-1] ? AMIN[WACC-1:0] : AMAX[WACC-1:0];
    else         acc_next = sum;
`else
    acc_next = sum;
`endif
    a64    = 64'(acc_q);
    fin_hi = a64 > OMAX;
    fin_lo = a64 < OMIN;
  end

  always_comb begin
    s1_vld_d  = hs;
    s1_prod_d = s1_prod_q;
    s1_last_d = s1_last_q;
    s1_ovf_d  = s1_ovf_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    od_d      = od_q;
    oovf_d    = oovf_q;
    ocnt_d    = ocnt_q;

    if (hs) begin
      s1_prod_d = mul_p;
      s1_last_d = i_last;
      s1_ovf_d  = mul_ovf;
    end

    if (s1_vld_q) begin
      acc_d = acc_next;
      ovf_d = ovf_q | s1_ovf_q | add_ovf;
      cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    end

    if (state_q == ST_FLUSH && !last_pending) begin
      if (fin_hi)      od_d = OMAX[WO-1:0];
      else if (fin_lo) od_d = OMIN[WO-1:0];
      else             od_d = acc_q[WO-1:0];
      oovf_d = ovf_q | fin_hi | fin_lo;
      ocnt_d = cnt_q;
    end

    if (state_q == ST_OUT && o_ready) begin
      acc_d = '0;
      ovf_d = 1'b0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_vld_q  <= 1'b0;
      s1_prod_q <= '0;
      s1_last_q <= 1'b0;
      s1_ovf_q  <= 1'b0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      od_q      <= '0;
      oovf_q    <= 1'b0;
      ocnt_q    <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_prod_q <= s1_prod_d;
      s1_last_q <= s1_last_d;
      s1_ovf_q  <= s1_ovf_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      od_q      <= od_d;
      oovf_q    <= oovf_d;
      ocnt_q    <= ocnt_d;
    end
  end

  assign o_data     = od_q;
  assign o_overflow = oovf_q;
  assign o_count    = ocnt_q;

endmodule

// File: tb/tb_fxp_dot_accumulator.sv
// Directed bench for fxp_dot_accumulator (default parameters, Q8.8 x Q8.8
// into Q12.8 with 4 guard bits). Inputs are driven and outputs sampled on
// the falling clock edge.
module tb_fxp_dot_accumulator;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_ready;
  logic [15:0] i_a = '0;
  logic [15:0] i_b = '0;
  logic        i_last = 1'b0;
  logic        o_valid;
  logic        o_ready = 1'b0;
  logic [19:0] o_data;
  logic        o_overflow;
  logic [15:0] o_count;

  int vecs = 0;
  int miss = 0;

  always #5 clk = ~clk;

  fxp_dot_accumulator dut (
    .rstn      (rstn),
    .clk       (clk),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .i_a       (i_a),
    .i_b       (i_b),
    .i_last    (i_last),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_data    (o_data),
    .o_overflow(o_overflow),
    .o_count   (o_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One beat: handshake happens on the rising edge between the two negedges
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last);
    @(negedge clk);
    chk("i_ready_acc", 32'(i_ready), 32'd1);
    i_valid = 1'b1; i_a = a; i_b = b; i_last = last;
    @(negedge clk);
    i_valid = 1'b0; i_last = 1'b0;
  endtask

  // Called half a cycle after the last-beat edge E; result due after E+2
  task automatic wait_result(input string tag);
    chk({tag, "_vld_e0"}, 32'(o_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_vld_e1"}, 32'(o_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_vld_e2"}, 32'(o_valid), 32'd1);
  endtask

  task automatic check_out(input string tag, input logic [19:0] d, input logic ov,
                           input logic [15:0] c, input logic chk_data);
    if (chk_data) chk({tag, "_data"}, 32'(o_data), 32'(d));
    chk({tag, "_ovf"}, 32'(o_overflow), 32'(ov));
    chk({tag, "_cnt"}, 32'(o_count), 32'(c));
    chk({tag, "_irdy_out"}, 32'(i_ready), 32'd0);
  endtask

  task automatic accept(input string tag);
    o_ready = 1'b1;
    @(negedge clk);
    o_ready = 1'b0;
    chk({tag, "_vld_clr"}, 32'(o_valid), 32'd0);
  endtask

  initial begin
    // ---- reset state ----
    #1;
    chk("rst_i_ready", 32'(i_ready), 32'd0);
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o_data",  32'(o_data),  32'd0);
    chk("rst_o_ovf",   32'(o_overflow), 32'd0);
    chk("rst_o_cnt",   32'(o_count), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("post_rst_i_ready", 32'(i_ready), 32'd1);

    // ---- single beat: 1.5 * 2.0 = 3.0 ----
    send(16'h0180, 16'h0200, 1'b1);
    wait_result("single");
    check_out("single", 20'h00300, 1'b0, 16'd1, 1'b1);
    accept("single");

    // ---- three beats with gaps: 3.0 - 0.5 + 1.0 = 3.5 ----
    send(16'h0180, 16'h0200, 1'b0);
    repeat (2) @(negedge clk);
    send(16'hFF00, 16'h0080, 1'b0);
    repeat (3) @(negedge clk);
    send(16'h0040, 16'h0400, 1'b1);
    wait_result("three");
    check_out("three", 20'h00380, 1'b0, 16'd3, 1'b1);
    accept("three");

    // ---- final saturation with backpressure: 2 * 127*127 = 32258 ----
    send(16'h7F00, 16'h7F00, 1'b0);
    send(16'h7F00, 16'h7F00, 1'b1);
    wait_result("sat");
    check_out("sat", 20'h7FFFF, 1'b1, 16'd2, 1'b1);
    // Next packet offered while the result is held
    i_valid = 1'b1; i_a = 16'h0100; i_b = 16'h0100; i_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_vld", 32'(o_valid), 32'd1);
      check_out("bp", 20'h7FFFF, 1'b1, 16'd2, 1'b1);
    end
    accept("bp");
    chk("bp_irdy_back", 32'(i_ready), 32'd1);
    @(negedge clk);  // handshake of 1.0*1.0 happened on the edge just passed
    i_valid = 1'b0; i_last = 1'b0;
    wait_result("after_bp");
    check_out("after_bp", 20'h00100, 1'b0, 16'd1, 1'b1);
    accept("after_bp");

    // ---- accumulator overflow: 3 * 127*127 exceeds Q16.8 ----
    send(16'h7F00, 16'h7F00, 1'b0);
    send(16'h7F00, 16'h7F00, 1'b0);
    send(16'h7F00, 16'h7F00, 1'b1);
    wait_result("accovf");
`ifdef FXP_ACC_SATURATE_EN
    check_out("accovf", 20'h7FFFF, 1'b1, 16'd3, 1'b1);
`else
    check_out("accovf", 20'h00000, 1'b1, 16'd3, 1'b0);
`endif
    accept("accovf");

    // ---- reset mid-packet after 2 of 3 beats ----
    send(16'h0100, 16'h0100, 1'b0);
    send(16'h0100, 16'h0100, 1'b0);
    rstn = 1'b0;
    #1;
    chk("midrst_o_data",  32'(o_data),  32'd0);
    chk("midrst_o_ovf",   32'(o_overflow), 32'd0);
    chk("midrst_o_cnt",   32'(o_count), 32'd0);
    chk("midrst_o_valid", 32'(o_valid), 32'd0);
    chk("midrst_i_ready", 32'(i_ready), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    send(16'h0080, 16'h0080, 1'b1);
    wait_result("postrst");
    check_out("postrst", 20'h00040, 1'b0, 16'd1, 1'b1);
    accept("postrst");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
